// File: rtl/mux_4_64b_arbiter.sv
// Round-robin arbiter and burst sequencer that shares one 64-bit downstream channel among four requesters.
// Each grant streams beats until the owner's LAST beat or until MAX_BEATS beats, whichever comes first.
module mux_4_64b_arbiter #(
    parameter int MAX_BEATS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  REQ,
    input  logic [3:0]  LAST,
    input  logic [63:0] A,
    input  logic [63:0] B,
    input  logic [63:0] C,
    input  logic [63:0] D,
    output logic [3:0]  GNT,
    output logic [1:0]  SELECTOR,
    output logic [63:0] F,
    output logic        F_VALID,
    input  logic        F_READY,
    output logic        F_LAST,
    output logic        TRUNC
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] CNT_CAP = 8'(MAX_BEATS - 1);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        trunc_q, trunc_d;

    logic [7:0]  req_dbl;
    logic [3:0]  req_rot;
    logic [1:0]  win_off;
    logic [1:0]  winner;
    logic        lane_req;
    logic        lane_last;
    logic        at_cap;
    logic        xfer;
    logic        grant_end;

    // Rotating REQ so bit 0 is the pointer's lane turns round-robin into a fixed priority scan.
    assign req_dbl = {REQ, REQ};
    assign req_rot = req_dbl[ptr_q +: 4];

    always_comb begin
        win_off = 2'd3;
        if (req_rot[0]) begin
            win_off = 2'd0;
        end else if (req_rot[1]) begin
            win_off = 2'd1;
        end else if (req_rot[2]) begin
            win_off = 2'd2;
        end
    end

    assign winner = ptr_q + win_off;

    always_comb begin
        F = A;
        case (sel_q)
            2'd0: F = A;
            2'd1: F = B;
            2'd2: F = C;
            2'd3: F = D;
            default: F = A;
        endcase
    end

    assign lane_req  = REQ[sel_q];
    assign lane_last = LAST[sel_q];
    assign at_cap    = (cnt_q == CNT_CAP);

    // F_VALID depends only on state, owner and REQ, never on F_READY.
    assign F_VALID   = (state_q == BUSY) & lane_req;
    assign xfer      = F_VALID & F_READY;
    assign F_LAST    = F_VALID & (lane_last | at_cap);
    assign grant_end = xfer & (lane_last | at_cap);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
            assign GNT[gi] = xfer & (sel_q == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        trunc_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ != 4'd0) begin
                    sel_d   = winner;
                    cnt_d   = 8'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // Clearing CNT at release keeps it within 0..MAX_BEATS-1.
                if (grant_end) begin
                    state_d = IDLE;
                    ptr_d   = sel_q + 2'd1;
                    cnt_d   = 8'd0;
                    trunc_d = at_cap & ~lane_last;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
            cnt_q   <= 8'd0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    assign SELECTOR = sel_q;
    assign TRUNC    = trunc_q;

endmodule

// File: tb/tb_mux_4_64b_arbiter.sv
// Bench for mux_4_64b_arbiter: directed scenarios plus randomized traffic against a
// burst-level reference model (owner, beats-so-far, next-priority lane).
module tb_mux_4_64b_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  REQ;
    logic [3:0]  LAST;
    logic [63:0] A, B, C, D;
    logic [3:0]  GNT;
    logic [1:0]  SELECTOR;
    logic [63:0] F;
    logic        F_VALID;
    logic        F_READY;
    logic        F_LAST;
    logic        TRUNC;

    mux_4_64b_arbiter #(.MAX_BEATS(MAXB)) dut (
        .clk(clk), .reset(reset), .REQ(REQ), .LAST(LAST),
        .A(A), .B(B), .C(C), .D(D),
        .GNT(GNT), .SELECTOR(SELECTOR), .F(F), .F_VALID(F_VALID),
        .F_READY(F_READY), .F_LAST(F_LAST), .TRUNC(TRUNC)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: burst-level view of the channel.
    bit model_known = 0;
    bit m_busy;
    int m_sel, m_ptr, m_beats;
    bit m_trunc;

    // Per-lane traffic generator: each active lane offers a burst of lane_len beats.
    bit lane_active [4];
    int lane_len    [4];
    int lane_sent   [4];
    int rearm_mode = 0;
    logic [63:0] din [4];

    // Observed transfers (from DUT outputs) for scenario-level checks.
    int          obs_lane [$];
    logic [63:0] obs_data [$];
    bit          obs_last [$];
    int          obs_cyc  [$];
    int          obs_trunc_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_logs();
        obs_lane.delete();
        obs_data.delete();
        obs_last.delete();
        obs_cyc.delete();
        obs_trunc_cnt = 0;
    endtask

    task automatic start_lane(input int i, input int len);
        lane_active[i] = 1;
        lane_len[i]    = len;
        lane_sent[i]   = 0;
    endtask

    task automatic step(input bit rst_in, input bit ready_in, input logic [3:0] drop);
        bit          exp_valid, exp_xfer, exp_last;
        logic [3:0]  exp_gnt;
        int          w;
        logic [31:0] hi;
        exp_xfer = 0;
        reset    = rst_in;
        F_READY  = ready_in;
        for (int i = 0; i < 4; i++) begin
            if (!lane_active[i] && rearm_mode == 1) start_lane(i, 1);
            if (!lane_active[i] && rearm_mode == 2 && $urandom_range(0, 3) == 0)
                start_lane(i, $urandom_range(1, 7));
            hi      = (rearm_mode == 2) ? 32'($urandom) : 32'd0;
            REQ[i]  = lane_active[i] && !drop[i];
            LAST[i] = lane_active[i] ? (lane_sent[i] + 1 == lane_len[i]) : 1'($urandom_range(0, 1));
            din[i]  = {hi, 32'(lane_sent[i] + 1)};
        end
        A = din[0]; B = din[1]; C = din[2]; D = din[3];

        @(negedge clk);
        if (model_known) begin
            exp_valid = m_busy && REQ[m_sel];
            exp_xfer  = exp_valid && ready_in;
            exp_last  = exp_valid && (LAST[m_sel] || m_beats == MAXB - 1);
            exp_gnt   = exp_xfer ? 4'(1 << m_sel) : 4'd0;
            check("gnt",      64'(GNT),      64'(exp_gnt));
            check("f_valid",  64'(F_VALID),  64'(exp_valid));
            check("f_last",   64'(F_LAST),   64'(exp_last));
            check("selector", 64'(SELECTOR), 64'(m_sel));
            check("trunc",    64'(TRUNC),    64'(m_trunc));
            check("f_data",   F,             din[m_sel]);
            if (TRUNC === 1'b1) obs_trunc_cnt++;
            if (GNT !== 4'd0) begin
                obs_lane.push_back(int'(SELECTOR));
                obs_data.push_back(F);
                obs_last.push_back(F_LAST);
                obs_cyc.push_back(cyc);
                $display("XFER cyc=%0d lane=%0d data=%h last=%0b", cyc, SELECTOR, F, F_LAST);
            end
        end

        @(posedge clk);
        cyc++;
        if (rst_in) begin
            model_known = 1;
            m_busy = 0; m_sel = 0; m_ptr = 0; m_beats = 0; m_trunc = 0;
            for (int i = 0; i < 4; i++) lane_active[i] = 0;
        end else if (model_known) begin
            m_trunc = 0;
            if (!m_busy) begin
                if (REQ != 4'd0) begin
                    w = -1;
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && REQ[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
                    m_sel = w; m_beats = 0; m_busy = 1;
                end
            end else if (exp_xfer) begin
                m_beats++;
                lane_sent[m_sel]++;
                if (lane_sent[m_sel] == lane_len[m_sel]) lane_active[m_sel] = 0;
                if (LAST[m_sel] || m_beats == MAXB) begin
                    m_trunc = !LAST[m_sel];
                    m_busy  = 0;
                    m_ptr   = (m_sel + 1) % 4;
                    // A truncated burst keeps its remaining beats and re-arbitrates.
                end
            end
        end
        #1;
    endtask

    int rcyc;

    initial begin
        reset = 1; REQ = 0; LAST = 0; F_READY = 0;
        A = 0; B = 0; C = 0; D = 0;
        for (int i = 0; i < 4; i++) begin
            lane_active[i] = 0; lane_len[i] = 0; lane_sent[i] = 0; din[i] = 0;
        end
        #1;

        // Reset then idle.
        step(1, 1, 4'd0);
        step(1, 1, 4'd0);
        clear_logs();
        for (int n = 0; n < 5; n++) step(0, 1, 4'd0);
        check("idle_no_xfer", 64'(obs_lane.size()), 64'd0);

        // Everyone requesting single-beat bursts: rotation A,B,C,D,A with a bubble each.
        step(1, 1, 4'd0);
        clear_logs();
        rearm_mode = 1;
        for (int n = 0; n < 10; n++) step(0, 1, 4'd0);
        rearm_mode = 0;
        check("rot_count", 64'(obs_lane.size()), 64'd5);
        if (obs_lane.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                check("rot_lane", 64'(obs_lane[k]), 64'(k % 4));
                check("rot_last", 64'(obs_last[k]), 64'd1);
                if (k > 0) check("rot_gap", 64'(obs_cyc[k] - obs_cyc[k-1]), 64'd2);
            end
        end

        // B sends 1,2,3 while C waits.
        step(1, 1, 4'd0);
        clear_logs();
        start_lane(1, 3);
        start_lane(2, 1);
        for (int n = 0; n < 8; n++) step(0, 1, 4'd0);
        check("b_count", 64'(obs_lane.size()), 64'd4);
        if (obs_lane.size() == 4) begin
            for (int k = 0; k < 3; k++) begin
                check("b_lane", 64'(obs_lane[k]), 64'd1);
                check("b_data", obs_data[k], 64'(k + 1));
                check("b_last", 64'(obs_last[k]), 64'(k == 2));
            end
            check("c_lane", 64'(obs_lane[3]), 64'd2);
            check("c_gap",  64'(obs_cyc[3] - obs_cyc[2]), 64'd2);
        end

        // D sends 6 beats with MAX_BEATS=4: forced split 4 + 2.
        step(1, 1, 4'd0);
        clear_logs();
        start_lane(3, 6);
        for (int n = 0; n < 12; n++) step(0, 1, 4'd0);
        check("d_count", 64'(obs_lane.size()), 64'd6);
        check("d_trunc_pulses", 64'(obs_trunc_cnt), 64'd1);
        if (obs_lane.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                check("d_lane", 64'(obs_lane[k]), 64'd3);
                check("d_data", obs_data[k], 64'(k + 1));
                check("d_last", 64'(obs_last[k]), 64'(k == 3 || k == 5));
            end
            check("d_regrant_gap", 64'(obs_cyc[4] - obs_cyc[3]), 64'd2);
        end

        // A's grant with F_READY 1,0,0,1 and a one-cycle REQ drop.
        step(1, 1, 4'd0);
        clear_logs();
        start_lane(0, 3);
        step(0, 1, 4'd0);
        step(0, 1, 4'd0);
        step(0, 0, 4'd0);
        step(0, 0, 4'd0);
        step(0, 1, 4'b0001);
        step(0, 1, 4'd0);
        step(0, 1, 4'd0);
        step(0, 1, 4'd0);
        check("a_count", 64'(obs_lane.size()), 64'd3);
        if (obs_lane.size() == 3) begin
            check("a_gap1", 64'(obs_cyc[1] - obs_cyc[0]), 64'd4);
            check("a_gap2", 64'(obs_cyc[2] - obs_cyc[1]), 64'd1);
            for (int k = 0; k < 3; k++) check("a_data", obs_data[k], 64'(k + 1));
        end

        // Reset mid-burst, then C alone is served.
        step(1, 1, 4'd0);
        clear_logs();
        start_lane(0, 5);
        step(0, 1, 4'd0);
        step(0, 1, 4'd0);
        step(0, 1, 4'd0);
        rcyc = cyc;
        step(1, 0, 4'd0);
        start_lane(2, 1);
        for (int n = 0; n < 4; n++) step(0, 1, 4'd0);
        check("rst_count", 64'(obs_lane.size()), 64'd3);
        if (obs_lane.size() == 3) begin
            check("rst_c_lane", 64'(obs_lane[2]), 64'd2);
            check("rst_c_cyc",  64'(obs_cyc[2] - rcyc), 64'd2);
        end

        // Randomized traffic.
        step(1, 1, 4'd0);
        rearm_mode = 2;
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] drop;
            for (int i = 0; i < 4; i++) drop[i] = ($urandom_range(0, 9) == 0);
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0), drop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
